// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: one-cycle base ops, WIDTH-cycle shift-add multiply and restoring divide
// ready/valid request and result handshake with flush and async reset
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2:0]       mop_q, mop_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] upper_imm;
  logic [WIDTH-1:0] base_res;

  assign shamt     = b[SW-1:0];
  assign upper_imm = {b[WIDTH-1:12], 12'b0};

  always_comb begin
    base_res = '0;
    case (op)
      5'b00000: base_res = a + b;
      5'b00001: base_res = a - b;
      5'b00010: base_res = a & b;
      5'b00011: base_res = a | b;
      5'b00100: base_res = a ^ b;
      5'b00101: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      5'b00110: base_res = {{(WIDTH-1){1'b0}}, a < b};
      5'b01000: base_res = a + upper_imm;
      5'b01001: base_res = upper_imm;
      5'b01010: base_res = a << shamt;
      5'b01011: base_res = $signed(a) >>> shamt;
      5'b01100: base_res = a >> shamt;
      default:  base_res = '0;
    endcase
  end

  // M-ops run on magnitudes; neg records whether the final result must be negated
  logic             m_op, sa, sb, a_neg, b_neg, is_div, is_rem, div_zero, ovf, neg_in;
  logic [WIDTH-1:0] opa, opb, special_res, idle_res;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op[2:0])
      3'b001, 3'b100, 3'b110: begin sa = 1'b1; sb = 1'b1; end
      3'b010:                 sa = 1'b1;
      default:                ;
    endcase
  end

  assign m_op        = (op[4:3] == 2'b10);
  assign a_neg       = sa & a[WIDTH-1];
  assign b_neg       = sb & b[WIDTH-1];
  assign opa         = a_neg ? -a : a;
  assign opb         = b_neg ? -b : b;
  assign is_div      = op[2];
  assign is_rem      = op[2] & op[1];
  assign div_zero    = is_div && (b == '0);
  assign ovf         = is_div && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign special_res = div_zero ? (is_rem ? a : '1) : (is_rem ? '0 : a);
  assign neg_in      = is_rem ? a_neg : (a_neg ^ b_neg);
  assign idle_res    = m_op ? special_res : base_res;

  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [WIDTH-1:0]   acc_mul, mq_mul, acc_div, mq_div, mul_res, div_res, fin_res;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               q_bit;

  assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_mul = mul_sum[WIDTH:1];
  assign mq_mul  = {mul_sum[0], mq_q[WIDTH-1:1]};

  // remainder < divisor, so the borrow bit of the (WIDTH+1)-bit subtract decides the quotient bit
  assign rem_sh  = {acc_q, mq_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, mcand_q};
  assign q_bit   = ~diff[WIDTH];
  assign acc_div = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign mq_div  = {mq_q[WIDTH-2:0], q_bit};

  assign prod    = {acc_mul, mq_mul};
  assign prod_s  = neg_q ? -prod : prod;
  assign mul_res = (mop_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
  assign div_res = mop_q[1] ? (neg_q ? -acc_div : acc_div) : (neg_q ? -mq_div : mq_div);
  assign fin_res = mop_q[2] ? div_res : mul_res;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    mcand_d  = mcand_q;
    mop_d    = mop_q;
    neg_d    = neg_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mop_d = op[2:0];
          if (m_op && !div_zero && !ovf) begin
            state_d = CALC;
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = is_div ? opb : opa;
            mq_d    = is_div ? opa : opb;
            neg_d   = neg_in;
          end else begin
            state_d  = DONE;
            result_d = idle_res;
            zero_d   = (idle_res == '0);
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + SW'(1);
        acc_d = mop_q[2] ? acc_div : acc_mul;
        mq_d  = mop_q[2] ? mq_div : mq_mul;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = fin_res;
          zero_d   = (fin_res == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          result_d = '0;
          zero_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = '0;
      zero_d   = 1'b0;
    end
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      mcand_q     <= '0;
      mop_q       <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      mcand_q     <= mcand_d;
      mop_q       <= mop_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu at WIDTH=32
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  op = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: pops the scoreboard on each result handshake
  exp_t m_e;
  int   first_cyc = 0;
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) first_cyc = cyc;
      ov_prev = out_valid;
      if (!out_valid) begin
        chk("idle_result", result, 32'd0);
        chk("idle_zero", {31'd0, zero}, 32'd0);
      end else if (out_ready) begin
        chk("valid_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("result", result, m_e.res);
          chk("zero", {31'd0, zero}, {31'd0, m_e.z});
          chk("latency", 32'(first_cyc - m_e.acc), 32'(m_e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input int lat, input bit push);
    int   t;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready && push) begin
      e.res = r; e.z = (r == 32'd0); e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] r, input int lat);
    issue(o, x, y, r, lat, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(5'b00000, 32'd5, 32'hFFFFFFFB, 32'd0, 1);
    run(5'b00001, 32'd3, 32'd5, 32'hFFFFFFFE, 1);
    run(5'b00010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
    run(5'b00011, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1);
    run(5'b00101, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
    run(5'b00110, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
    run(5'b01010, 32'd1, 32'h00000021, 32'd2, 1);
    run(5'b01011, 32'h80000000, 32'd4, 32'hF8000000, 1);
    run(5'b01100, 32'h80000000, 32'd4, 32'h08000000, 1);
    run(5'b01000, 32'd1, 32'h12345FFF, 32'h12345001, 1);
    run(5'b01001, 32'd1, 32'h12345FFF, 32'h12345000, 1);
    run(5'b00111, 32'd5, 32'd6, 32'd0, 1);
    run(5'b11000, 32'd5, 32'd6, 32'd0, 1);

    run(5'b10000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run(5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run(5'b10010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    run(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run(5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run(5'b10101, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    run(5'b10111, 32'd9, 32'd0, 32'd9, 1);
    run(5'b10100, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    run(5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run(5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run(5'b10101, 32'd100, 32'd7, 32'd14, 33);
    run(5'b10111, 32'd100, 32'd7, 32'd2, 33);

    // backpressure: result must hold while out_ready is low
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(5'b00100, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, 32'hF00FF00F);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // reset in the middle of a divide
    issue(5'b10101, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run(5'b00000, 32'd2, 32'd3, 32'd5, 1);

    // flush in the middle of a divide
    issue(5'b10101, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(negedge clk);

    // a request together with flush is ignored
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_req_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_req_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    run(5'b00000, 32'd2, 32'd3, 32'd5, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
